gray_code_converter_pipe: RTL

Parametrised, pipelined, bidirectional Gray/binary converter with valid/ready handshake on both sides.
- Mode is selected per transaction: Gray->binary or binary->Gray.
- Gray->binary uses an MSB-first prefix-XOR chain, split across STAGES register stages so wide words meet timing.
- Sits between CDC Gray-pointer synchronisers and the binary consumers (FIFO occupancy logic, counters, displays).

---
 rtl/gray_code_converter_pipe_pkg.sv | 13 +
 rtl/gray_code_converter_pipe_if.sv | 34 +++
 rtl/gray_code_converter_pipe_stage.sv | 64 ++++++
 rtl/gray_code_converter_pipe.sv | 93 +++++++++
 4 files changed

// File: rtl/gray_code_converter_pipe_pkg.sv
// Shared constants and helpers for the pipelined Gray/binary converter.
// Optional step checking is enabled with GRAY_CONV_STEP_CHECK_EN.
package gray_conv_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  // Gray bits resolved per stage, MSB-first; the last stage takes what is left.
  function automatic int gray_bits_per_stage(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/gray_code_converter_pipe_if.sv
// Valid/ready bus for the Gray/binary converter: input word side plus result side.
// out_step_err exists only when GRAY_CONV_STEP_CHECK_EN is defined.
interface gray_code_converter_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
`ifdef GRAY_CONV_STEP_CHECK_EN
  logic             out_step_err;
`endif

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
`ifdef GRAY_CONV_STEP_CHECK_EN
    , output out_step_err
`endif
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
`ifdef GRAY_CONV_STEP_CHECK_EN
    , input out_step_err
`endif
  );

endinterface

// File: rtl/gray_code_converter_pipe_stage.sv
// One register stage: resolves Gray bits HI..LO of the prefix-XOR chain, or
// (first stage only) performs the whole binary->Gray step.
module gray_conv_stage
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HI    = 7,
  parameter int LO    = 0,
  parameter bit FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  output logic             vld_o,
  output logic             mode_o,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  logic             vld_q, mode_q, carry_q, carry_d;
  logic [WIDTH-1:0] data_q, data_d;

  // data holds resolved binary above this slice and raw Gray below it
  always_comb begin
    data_d  = data_i;
    carry_d = carry_i;
    if (mode_i == MODE_B2G) begin
      if (FIRST) data_d = data_i ^ (data_i >> 1);
    end else begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          carry_d   = carry_d ^ data_i[i];
          data_d[i] = carry_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        mode_q  <= mode_i;
        data_q  <= data_d;
        carry_q <= carry_d;
      end
    end
  end

  assign vld_o   = vld_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/gray_code_converter_pipe.sv
// Pipelined bidirectional Gray/binary converter with collapsing-bubble handshake.
// Define GRAY_CONV_STEP_CHECK_EN to add out_step_err (Gray Hamming-step checker).
module gray_code_converter_pipe
  import gray_conv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  gray_code_converter_pipe_if.slave bus
);

  localparam int GRP = gray_bits_per_stage(WIDTH, STAGES);

  // index 0 is the input word, index k+1 is the output of stage k
  logic [STAGES:0]            vld_pipe, mode_pipe, carry_pipe, en;
  logic [STAGES:0][WIDTH-1:0] data_pipe;
  logic                       unused_carry;

  assign vld_pipe[0]   = bus.in_valid;
  assign mode_pipe[0]  = bus.in_mode;
  assign data_pipe[0]  = bus.in_data;
  assign carry_pipe[0] = 1'b0;
  assign unused_carry  = carry_pipe[STAGES];

  always_comb begin
    en         = '0;
    en[STAGES] = bus.out_ready;
    for (int k = STAGES-1; k >= 0; k--) en[k] = !vld_pipe[k+1] || en[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = WIDTH-1 - k*GRP;
    localparam int LO = (k == STAGES-1 || HI-GRP+1 < 0) ? 0 : HI-GRP+1;
    gray_conv_stage #(
      .WIDTH (WIDTH),
      .HI    (HI),
      .LO    (LO),
      .FIRST (k == 0)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en[k]),
      .vld_i   (vld_pipe[k]),
      .mode_i  (mode_pipe[k]),
      .data_i  (data_pipe[k]),
      .carry_i (carry_pipe[k]),
      .vld_o   (vld_pipe[k+1]),
      .mode_o  (mode_pipe[k+1]),
      .data_o  (data_pipe[k+1]),
      .carry_o (carry_pipe[k+1])
    );
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_mode  = mode_pipe[STAGES];
  assign bus.out_data  = data_pipe[STAGES];

`ifdef GRAY_CONV_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q, diff;
  logic             have_q, err_in;
  logic [STAGES:0]  err_q;

  // more than one differing bit <=> diff has a set bit besides its lowest one
  assign diff   = bus.in_data ^ prev_q;
  assign err_in = (bus.in_mode == MODE_G2B) && have_q && (|(diff & (diff - WIDTH'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      have_q <= 1'b0;
    end else if (bus.in_valid && en[0] && bus.in_mode == MODE_G2B) begin
      prev_q <= bus.in_data;
      have_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q[STAGES:1] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (en[k] && vld_pipe[k]) err_q[k+1] <= (k == 0) ? err_in : err_q[k];
    end
  end

  assign err_q[0]         = 1'b0;
  assign bus.out_step_err = err_q[STAGES];
`endif

endmodule
